// File: rtl/phy_rx_pkg.sv
// -----------------------------------------------------------------------------
// phy_rx_pkg
//
// Shared definitions for the PHY RX lane front end.
//
// Contents:
//    RX_WIDTH        bits per parallel word
//    RX_CNT_W        width of the bit-position counter (log2 of RX_WIDTH)
//    RX_COMMA        alignment / idle symbol (K28.5-style comma byte)
//    RX_COMMA_COUNT  consecutive aligned commas needed before data flows
//    rx_state_t      alignment state machine encoding
//
// No ports; this file only provides types and constants.
// -----------------------------------------------------------------------------
package phy_rx_pkg;

   localparam int RX_WIDTH = 8;

   localparam int RX_CNT_W = 3;

   localparam logic [RX_WIDTH-1:0] RX_COMMA = 8'hBC;

   localparam int RX_COMMA_COUNT = 4;

   // The encodings are fixed so other blocks can decode a probed state value
   // without depending on tool-chosen state assignment.
   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } rx_state_t;

endpackage : phy_rx_pkg

// File: rtl/rx_shift_reg.sv
// -----------------------------------------------------------------------------
// rx_shift_reg
//
// Serial-in shift register for the RX alignment front end. Every clock the
// newest serial bit is appended at the LSB end, so the stream arrives MSB
// first. The candidate word "cand" is the register contents combined with the
// bit currently on data_in, which lets the parent compare a full word against
// the comma in the same cycle its last bit is sampled.
//
// Ports:
//    clk_32f  in   serial bit clock, rising edge
//    reset    in   asynchronous, active-low
//    data_in  in   serial bit
//    cand     out  WIDTH-bit candidate word {older bits, data_in}
// -----------------------------------------------------------------------------
module rx_shift_reg
   import phy_rx_pkg::*;
#(
   parameter int WIDTH = RX_WIDTH
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] cand
);

   // Only WIDTH-1 older bits are stored. The oldest bit of cand would be
   // shifted out on the next edge anyway, so keeping it would be a dead flop.
   logic [WIDTH-2:0] shift;

   // The candidate is purely combinational so the parent sees the word ending
   // in the bit being sampled right now.
   assign cand = {shift, data_in};

   // The register shifts unconditionally in every alignment state; the parent
   // decides what to do with the word, this block never stalls.
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         shift <= '0;
      end else begin
         shift <= cand[WIDTH-2:0];
      end
   end

endmodule : rx_shift_reg

// File: rtl/serial_paralelo_rx_sync.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx_sync
//
// Upstream stage of the PHY RX lane demux. It takes the serial stream at
// clk_32f, hunts for the comma symbol to find byte alignment, and declares the
// link active after COMMA_COUNT consecutive commas seen on word boundaries.
// Once active it emits one parallel word every WIDTH clocks with a one-cycle
// strobe. Idle commas are still strobed out but with valid_out low, so the
// downstream demux only consumes real data.
//
// Ports:
//    clk_32f      in   serial bit clock; all logic on rising edge
//    reset        in   asynchronous, active-low (0 = reset)
//    data_in      in   serial bit, MSB of each word first
//    data_out     out  last assembled word, held between strobes
//    word_strobe  out  one-cycle pulse when data_out updates
//    valid_out    out  word on data_out is data (not a comma); held
//    active       out  alignment locked, words are flowing
// -----------------------------------------------------------------------------
module serial_paralelo_rx_sync
   import phy_rx_pkg::*;
#(
   parameter int                WIDTH       = RX_WIDTH,
   parameter logic [WIDTH-1:0]  COMMA       = RX_COMMA,
   parameter int                COMMA_COUNT = RX_COMMA_COUNT,
   parameter int                CNT_W       = RX_CNT_W
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             word_strobe,
   output logic             valid_out,
   output logic             active
);

   // The comma counter must be able to hold COMMA_COUNT itself.
   localparam int CC_W = (COMMA_COUNT < 2) ? 1 : $clog2(COMMA_COUNT + 1);

   // Bit position of the last bit in a word; the counter wraps here.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // Comma count at which one more boundary comma completes alignment.
   localparam logic [CC_W-1:0] COMMA_LAST = CC_W'(COMMA_COUNT - 1);

   rx_state_t          state;
   rx_state_t          state_nxt;
   logic [CNT_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]   bit_cnt_nxt;
   logic [CC_W-1:0]    comma_cnt;
   logic [CC_W-1:0]    comma_cnt_nxt;
   logic [WIDTH-1:0]   data_nxt;
   logic               strobe_nxt;
   logic               valid_nxt;

   logic [WIDTH-1:0]   cand;
   logic               cand_is_comma;
   logic               at_boundary;

   rx_shift_reg #(
      .WIDTH   (WIDTH)
   ) u_shift (
      .clk_32f (clk_32f),
      .reset   (reset),
      .data_in (data_in),
      .cand    (cand)
   );

   // The counter value describes the bit being sampled this cycle, so a
   // value of WIDTH-1 means cand holds a complete, aligned word.
   assign cand_is_comma = (cand == COMMA);
   assign at_boundary   = (bit_cnt == CNT_LAST);

   // Decoded straight from the registered state, so it rises the cycle after
   // the final alignment comma and drops asynchronously with reset.
   assign active = (state == ACTIVE);

   // State, counters and the output word are all registered together so the
   // strobe, word and valid flag always change on the same edge.
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state       <= SEARCH;
         bit_cnt     <= '0;
         comma_cnt   <= '0;
         data_out    <= '0;
         word_strobe <= 1'b0;
         valid_out   <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_cnt     <= bit_cnt_nxt;
         comma_cnt   <= comma_cnt_nxt;
         data_out    <= data_nxt;
         word_strobe <= strobe_nxt;
         valid_out   <= valid_nxt;
      end
   end

   // Alignment state machine.
   //  SEARCH checks every bit position for a comma; the first hit fixes the
   //  word phase. SYNC only looks at word boundaries and requires the commas
   //  to keep coming back-to-back; any other word there means the first hit
   //  was a false match, so we drop back to a full search. That mismatching
   //  word is deliberately not re-tested as a new comma. ACTIVE is sticky
   //  until reset: once locked, comma-shaped patterns straddling words are
   //  just data and must not move the alignment.
   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      comma_cnt_nxt = comma_cnt;
      data_nxt      = data_out;
      valid_nxt     = valid_out;
      strobe_nxt    = 1'b0;

      case (state)
         SEARCH: begin
            bit_cnt_nxt   = '0;
            comma_cnt_nxt = '0;
            if (cand_is_comma) begin
               comma_cnt_nxt = CC_W'(1);
               state_nxt     = (COMMA_COUNT == 1) ? ACTIVE : SYNC;
            end
         end

         SYNC: begin
            bit_cnt_nxt = at_boundary ? '0 : bit_cnt + 1'b1;
            if (at_boundary) begin
               if (cand_is_comma) begin
                  comma_cnt_nxt = comma_cnt + 1'b1;
                  if (comma_cnt == COMMA_LAST) begin
                     state_nxt = ACTIVE;
                  end
               end else begin
                  comma_cnt_nxt = '0;
                  bit_cnt_nxt   = '0;
                  state_nxt     = SEARCH;
               end
            end
         end

         ACTIVE: begin
            bit_cnt_nxt = at_boundary ? '0 : bit_cnt + 1'b1;
            if (at_boundary) begin
               data_nxt   = cand;
               strobe_nxt = 1'b1;
               valid_nxt  = !cand_is_comma;
            end
         end

         default: begin
            state_nxt     = SEARCH;
            bit_cnt_nxt   = '0;
            comma_cnt_nxt = '0;
         end
      endcase
   end

endmodule : serial_paralelo_rx_sync

// File: tb/tb_serial_paralelo_rx_sync.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_rx_sync
//
// Directed bench for the RX alignment front end. Stimulus pushes the expected
// {word, valid} for every word that should be strobed; a monitor on the
// falling edge pops one entry per word_strobe and compares, and also checks
// that consecutive strobes within one lock are exactly 8 cycles apart.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_rx_sync;
   import phy_rx_pkg::*;

   logic       clk_32f = 1'b0;
   logic       reset;
   logic       data_in;
   logic [7:0] data_out;
   logic       word_strobe;
   logic       valid_out;
   logic       active;

   typedef struct packed {
      logic [7:0] data;
      logic       valid;
   } exp_t;

   exp_t exp_q[$];

   int error_count = 0;
   int check_count = 0;
   int cycle_count = 0;
   int last_strobe_cycle = 0;
   bit have_prev = 1'b0;

   serial_paralelo_rx_sync dut (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .data_in     (data_in),
      .data_out    (data_out),
      .word_strobe (word_strobe),
      .valid_out   (valid_out),
      .active      (active)
   );

   // 10 ns serial bit clock.
   always #5 clk_32f = ~clk_32f;

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one bit; returns 1 ns after the edge that sampled it.
   task automatic sendBit(input logic b);
      data_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   // Send a word MSB first, optionally registering the strobe it must cause.
   task automatic applyStimulus(input logic [7:0] word, input bit expect_strobe, input bit expect_valid);
      exp_t e;
      if (expect_strobe) begin
         e.data  = word;
         e.valid = expect_valid;
         exp_q.push_back(e);
      end
      for (int i = 7; i >= 0; i--) sendBit(word[i]);
   endtask

   // Pulse reset low for a few cycles with junk on data_in.
   task automatic holdReset(input int cycles);
      reset = 1'b0;
      repeat (cycles) sendBit(1'($urandom_range(0, 1)));
      reset = 1'b1;
   endtask

   // Four aligned commas; active must stay low until the last bit's edge.
   task automatic lockSequence(input string tag);
      logic [7:0] c;
      c = 8'hBC;
      repeat (3) applyStimulus(c, 1'b0, 1'b0);
      for (int i = 7; i >= 1; i--) sendBit(c[i]);
      checkOutput({tag, "_active_pre"}, 32'(active), 32'd0);
      sendBit(c[0]);
      checkOutput({tag, "_active_rise"}, 32'(active), 32'd1);
   endtask

   // Let the last strobe land, then every expected word must be consumed.
   task automatic drain(input string tag);
      sendBit(1'b0);
      sendBit(1'b0);
      checkOutput({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: compares each strobed word against the scoreboard and checks
   // the spacing between strobes of the same lock.
   always @(negedge clk_32f) begin
      exp_t e;
      cycle_count++;
      if (word_strobe === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL unexpected_strobe: got data 0x%0h valid %0b, expected no strobe at %0t",
                     data_out, valid_out, $time);
         end else begin
            e = exp_q.pop_front();
            checkOutput("strobe_data_out", 32'(data_out), 32'(e.data));
            checkOutput("strobe_valid_out", 32'(valid_out), 32'(e.valid));
         end
         if (have_prev) begin
            checkOutput("strobe_gap", 32'(cycle_count - last_strobe_cycle), 32'd8);
         end
         have_prev         = 1'b1;
         last_strobe_cycle = cycle_count;
      end
      if (reset !== 1'b1) have_prev = 1'b0;
   end

   initial begin
      reset   = 1'b0;
      data_in = 1'b0;
      @(posedge clk_32f);
      #1;

      // Long reset with random serial data: everything stays cleared.
      $display("[TB] reset hold");
      for (int i = 0; i < 20; i++) sendBit(1'($urandom_range(0, 1)));
      checkOutput("rst_data_out", 32'(data_out), 32'd0);
      checkOutput("rst_word_strobe", 32'(word_strobe), 32'd0);
      checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
      checkOutput("rst_active", 32'(active), 32'd0);
      reset = 1'b1;

      // Aligned lock straight after reset, then one data word.
      $display("[TB] aligned lock");
      lockSequence("t2");
      applyStimulus(8'h55, 1'b1, 1'b1);
      drain("t2");

      // 3-bit offset before the commas, then data / idle / data.
      $display("[TB] offset lock");
      holdReset(2);
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      lockSequence("t3");
      applyStimulus(8'hA3, 1'b1, 1'b1);
      applyStimulus(8'hBC, 1'b1, 1'b0);
      exp_q.push_back(exp_t'({8'h0F, 1'b0 | 1'b1}));
      for (int i = 7; i >= 4; i--) sendBit(1'(8'h0F >> i));
      checkOutput("hold_valid_out", 32'(valid_out), 32'd0);
      checkOutput("hold_data_out", 32'(data_out), 32'hBC);
      checkOutput("hold_word_strobe", 32'(word_strobe), 32'd0);
      for (int i = 3; i >= 0; i--) sendBit(1'(8'h0F >> i));
      drain("t3");

      // Broken comma run drops back to SEARCH and relocks later.
      $display("[TB] broken comma run");
      holdReset(2);
      applyStimulus(8'hBC, 1'b0, 1'b0);
      applyStimulus(8'hBC, 1'b0, 1'b0);
      applyStimulus(8'h12, 1'b0, 1'b0);
      checkOutput("t4_active_after_break", 32'(active), 32'd0);
      lockSequence("t4");
      applyStimulus(8'h7E, 1'b1, 1'b1);

      // 0x5B,0xC0 hides a comma across the word boundary; alignment holds.
      $display("[TB] straddling comma");
      applyStimulus(8'h5B, 1'b1, 1'b1);
      applyStimulus(8'hC0, 1'b1, 1'b1);

      // One-cycle reset mid-word while active; outputs clear at once.
      $display("[TB] mid-word reset");
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      checkOutput("t6_pre_active", 32'(active), 32'd1);
      checkOutput("t6_pre_data_out", 32'(data_out), 32'hC0);
      reset = 1'b0;
      #1;
      checkOutput("t6_async_data_out", 32'(data_out), 32'd0);
      checkOutput("t6_async_valid_out", 32'(valid_out), 32'd0);
      checkOutput("t6_async_active", 32'(active), 32'd0);
      checkOutput("t6_async_word_strobe", 32'(word_strobe), 32'd0);
      @(posedge clk_32f);
      #1;
      reset = 1'b1;
      lockSequence("t6");
      applyStimulus(8'h33, 1'b1, 1'b1);
      drain("t6");

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule : tb_serial_paralelo_rx_sync
